// File: rtl/mem_req_ctrl_pkg.sv
// Shared FSM state encoding and error codes for the memory request controller.
package mem_req_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] err_code_t;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MEM     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Issues a held Rd/Wr access per EX/MEM load/store, stalls the pipe until Done,
// registers load data, flags memory error / timeout / illegal op, counts accesses and hits.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_load,
    input  logic             req_store,
    input  logic             req_halt,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             mem_dump,
    input  logic             mem_done,
    input  logic             mem_stall,
    input  logic             mem_hit,
    input  logic             mem_err,
    input  logic [15:0]      mem_rdata,
    output logic             stall_pipe,
    output logic             resp_valid,
    output logic [15:0]      rdata_q,
    output logic             err_out,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              memop;
    logic              acc_inc;
    logic              hit_inc;
    logic              unused_mem_stall;

    // Done is the only completion signal; Stall is visible to the memory stage only.
    assign unused_mem_stall = mem_stall;

    assign memop   = req_valid & (req_load | req_store);
    assign acc_inc = (state == S_ACCESS) & mem_done & ~mem_err;
    assign hit_inc = acc_inc & mem_hit;

    assign resp_valid = (state == S_RESP);
    assign err_out    = (state == S_ERR);
    assign stall_pipe = (state == S_IDLE) ? memop : (state != S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_dump  <= 1'b0;
            rdata_q   <= '0;
            err_code  <= ERR_NONE;
            wait_cnt  <= '0;
        end else begin
            mem_dump <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_load && req_store) begin
                        state    <= S_ERR;
                        err_code <= ERR_ILLEGAL;
                    end else if (memop) begin
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        mem_rd    <= req_load;
                        mem_wr    <= req_store;
                        wait_cnt  <= '0;
                        state     <= S_ACCESS;
                    end else if (req_valid && req_halt) begin
                        mem_dump <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    // err wins over Done: a faulted access never completes or counts.
                    if (mem_err) begin
                        mem_rd   <= 1'b0;
                        mem_wr   <= 1'b0;
                        err_code <= ERR_MEM;
                        state    <= S_ERR;
                    end else if (mem_done) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (mem_rd) begin
                            rdata_q <= mem_rdata;
                        end
                        state <= S_RESP;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        mem_rd   <= 1'b0;
                        mem_wr   <= 1'b0;
                        err_code <= ERR_TIMEOUT;
                        state    <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_acc_cnt (
        .clk (clk),
        .rst (rst),
        .inc (acc_inc),
        .cnt (acc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_inc),
        .cnt (hit_cnt)
    );

endmodule
